// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: shared definitions for the UART command frame decoder.
//  - state_t   : FSM state encoding for uart_cmd_ctrl
//  - frame constants : header byte and command opcodes
//  - ERR_*     : err_code values reported when a frame is dropped
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_LEN,
        S_PAYLOAD,
        S_CHK,
        S_ISSUE,
        S_DRAIN
    } state_t;

    localparam logic [7:0] HDR_BYTE  = 8'h55;
    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_READ  = 8'h02;

    localparam logic [2:0] ERR_PARITY   = 3'd1;
    localparam logic [2:0] ERR_BAD_CMD  = 3'd2;
    localparam logic [2:0] ERR_BAD_LEN  = 3'd3;
    localparam logic [2:0] ERR_CHECKSUM = 3'd4;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd5;
    localparam logic [2:0] ERR_OVERRUN  = 3'd6;

    // States in which frame bytes are being collected (timeout armed).
    function automatic logic in_frame(input state_t s);
        return (s == S_CMD) || (s == S_ADDR) || (s == S_LEN) ||
               (s == S_PAYLOAD) || (s == S_CHK);
    endfunction

endpackage

// File: rtl/uart_cmd_buf.sv
// uart_cmd_buf: DEPTH x 8 payload register file.
//  clk, rst : clock, synchronous active-high reset (clears the read register only)
//  we/waddr/wdata : write port
//  raddr/rdata    : read port, rdata is registered (one cycle after raddr)
module uart_cmd_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) rdata <= 8'h00;
        else     rdata <= mem[raddr];
    end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: assembles uart_rx bytes into command frames
//  (55, CMD, A2, A1, A0, LEN, payload[write only], CHK), validates them,
//  then issues one command and streams the write payload.
//  clk, rst                         : clock, synchronous active-high reset
//  rx_data/rx_valid/rx_parity_err   : byte stream from uart_rx
//  cmd_valid/cmd_ready/cmd_wr/cmd_addr/cmd_len : command handshake + fields
//  wr_data/wr_valid/wr_ready        : payload stream handshake
//  err_valid/err_code               : dropped-frame pulse and sticky code
//  busy                             : high whenever not IDLE
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter int CLK_FREQ      = 100000000,
    parameter int UART_RATE     = 1000000,
    parameter int MAX_LEN       = 16,
    parameter int TIMEOUT_BYTES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_parity_err,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic        cmd_wr,
    output logic [23:0] cmd_addr,
    output logic [7:0]  cmd_len,
    output logic [7:0]  wr_data,
    output logic        wr_valid,
    input  logic        wr_ready,
    output logic        err_valid,
    output logic [2:0]  err_code,
    output logic        busy
);

    localparam int TO_CYCLES = (CLK_FREQ / UART_RATE) * 11 * TIMEOUT_BYTES;
    localparam int TW        = (TO_CYCLES > 2) ? $clog2(TO_CYCLES) : 1;
    localparam logic [TW-1:0] TO_RELOAD = TW'(TO_CYCLES - 1);
    localparam int AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_t        state, state_n;
    logic [7:0]    chk;
    logic [7:0]    idx;
    logic [1:0]    byte_cnt;
    logic [TW-1:0] to_cnt;
    logic          err_n;
    logic [2:0]    code_n;
    logic          frame_active;
    logic          timed_out;
    logic          buf_we;
    logic [7:0]    rd_idx;

    assign frame_active = in_frame(state);
    // A byte arriving on the expiry cycle wins over the timeout.
    assign timed_out    = frame_active && (to_cnt == '0) && !rx_valid;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        err_n   = 1'b0;
        code_n  = err_code;
        if (frame_active && rx_valid && rx_parity_err) begin
            err_n = 1'b1; code_n = ERR_PARITY; state_n = S_IDLE;
        end else if (timed_out) begin
            err_n = 1'b1; code_n = ERR_TIMEOUT; state_n = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (rx_valid && rx_data == HDR_BYTE) begin
                    if (rx_parity_err) begin
                        err_n = 1'b1; code_n = ERR_PARITY;
                    end else begin
                        state_n = S_CMD;
                    end
                end
                S_CMD: if (rx_valid) begin
                    if (rx_data == CMD_WRITE || rx_data == CMD_READ) state_n = S_ADDR;
                    else begin
                        err_n = 1'b1; code_n = ERR_BAD_CMD; state_n = S_IDLE;
                    end
                end
                S_ADDR: if (rx_valid && byte_cnt == 2'd2) state_n = S_LEN;
                S_LEN: if (rx_valid) begin
                    if (rx_data == 8'd0 || rx_data > MAX_LEN_B) begin
                        err_n = 1'b1; code_n = ERR_BAD_LEN; state_n = S_IDLE;
                    end else begin
                        state_n = cmd_wr ? S_PAYLOAD : S_CHK;
                    end
                end
                S_PAYLOAD: if (rx_valid && idx == cmd_len - 8'd1) state_n = S_CHK;
                S_CHK: if (rx_valid) begin
                    if (rx_data == chk) state_n = S_ISSUE;
                    else begin
                        err_n = 1'b1; code_n = ERR_CHECKSUM; state_n = S_IDLE;
                    end
                end
                S_ISSUE: if (cmd_ready) state_n = cmd_wr ? S_DRAIN : S_IDLE;
                S_DRAIN: if (wr_ready && idx == cmd_len - 8'd1) state_n = S_IDLE;
                default: state_n = S_IDLE;
            endcase
            // Overrun is reported but the command in flight keeps going.
            if ((state == S_ISSUE || state == S_DRAIN) && rx_valid) begin
                err_n = 1'b1; code_n = ERR_OVERRUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_valid <= 1'b0;
            err_code  <= 3'd0;
            to_cnt    <= '0;
            chk       <= 8'h00;
            idx       <= 8'h00;
            byte_cnt  <= 2'd0;
            cmd_wr    <= 1'b0;
            cmd_addr  <= 24'h0;
            cmd_len   <= 8'h00;
        end else begin
            err_valid <= err_n;
            if (err_n) err_code <= code_n;

            if (rx_valid)                           to_cnt <= TO_RELOAD;
            else if (frame_active && to_cnt != '0)  to_cnt <= to_cnt - 1'b1;

            case (state)
                S_IDLE: begin
                    chk      <= 8'h00;
                    byte_cnt <= 2'd0;
                end
                S_CMD: if (rx_valid) begin
                    chk    <= rx_data;
                    cmd_wr <= (rx_data == CMD_WRITE);
                end
                S_ADDR: if (rx_valid) begin
                    chk      <= chk ^ rx_data;
                    cmd_addr <= {cmd_addr[15:0], rx_data};
                    byte_cnt <= byte_cnt + 2'd1;
                end
                S_LEN: if (rx_valid) begin
                    chk     <= chk ^ rx_data;
                    cmd_len <= rx_data;
                    idx     <= 8'h00;
                end
                S_PAYLOAD: if (rx_valid) begin
                    chk <= chk ^ rx_data;
                    idx <= idx + 8'd1;
                end
                S_ISSUE: idx <= 8'h00;
                S_DRAIN: if (wr_ready) idx <= idx + 8'd1;
                default: ;
            endcase
        end
    end

    // Read one entry ahead on a handshake so wr_data tracks idx with no bubble.
    assign buf_we = (state == S_PAYLOAD) && rx_valid;
    assign rd_idx = (state == S_DRAIN) ? idx + {7'd0, wr_ready} : 8'h00;

    uart_cmd_buf #(.DEPTH(MAX_LEN), .AW(AW)) u_buf (
        .clk   (clk),
        .rst   (rst),
        .we    (buf_we),
        .waddr (idx[AW-1:0]),
        .wdata (rx_data),
        .raddr (rd_idx[AW-1:0]),
        .rdata (wr_data)
    );

    assign cmd_valid = (state == S_ISSUE);
    assign wr_valid  = (state == S_DRAIN);
    assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
`timescale 1ns/1ps
module tb_uart_cmd_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_parity_err = 1'b0;
    logic        cmd_valid, cmd_wr;
    logic        cmd_ready = 1'b1;
    logic [23:0] cmd_addr;
    logic [7:0]  cmd_len, wr_data;
    logic        wr_valid;
    logic        wr_ready = 1'b1;
    logic        err_valid, busy;
    logic [2:0]  err_code;

    always #5 clk = ~clk;

    uart_cmd_ctrl dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_parity_err(rx_parity_err), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wr_data(wr_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .err_valid(err_valid),
        .err_code(err_code), .busy(busy)
    );

    typedef struct packed {
        logic        wr;
        logic [23:0] addr;
        logic [7:0]  len;
    } cmd_t;

    cmd_t       exp_cmd[$];
    logic [7:0] exp_wr[$];
    logic [2:0] exp_err[$];
    logic [7:0] frm[$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: compares every DUT output event against the queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (cmd_valid) begin
                if (exp_cmd.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL unexpected_cmd: got wr=%0b addr=%h len=%0d expected none",
                             cmd_wr, cmd_addr, cmd_len);
                end else begin
                    check("cmd_wr",   32'(cmd_wr),   32'(exp_cmd[0].wr));
                    check("cmd_addr", 32'(cmd_addr), 32'(exp_cmd[0].addr));
                    check("cmd_len",  32'(cmd_len),  32'(exp_cmd[0].len));
                    if (cmd_ready) void'(exp_cmd.pop_front());
                end
            end
            if (wr_valid && wr_ready) begin
                if (exp_wr.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL unexpected_wr: got %h expected none", wr_data);
                end else begin
                    check("wr_data", 32'(wr_data), 32'(exp_wr.pop_front()));
                end
            end
            if (err_valid) begin
                if (exp_err.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL unexpected_err: got code %0d expected none", err_code);
                end else begin
                    check("err_code", 32'(err_code), 32'(exp_err.pop_front()));
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic par);
        repeat (2) @(posedge clk);
        #1;
        rx_data = b; rx_valid = 1'b1; rx_parity_err = par;
        @(posedge clk);
        #1;
        rx_valid = 1'b0; rx_parity_err = 1'b0;
    endtask

    task automatic send_frm();
        foreach (frm[i]) send_byte(frm[i], 1'b0);
    endtask

    // Builds a frame; payload (write only) is base, base+1, ...; CHK is XOR of CMD..payload.
    task automatic make_frame(input logic [7:0] cmd, input logic [23:0] a,
                              input logic [7:0] len, input logic [7:0] base);
        logic [7:0] x;
        frm = '{8'h55, cmd, a[23:16], a[15:8], a[7:0], len};
        x = cmd ^ a[23:16] ^ a[15:8] ^ a[7:0] ^ len;
        if (cmd == 8'h01) begin
            for (int i = 0; i < int'(len); i++) begin
                frm.push_back(base + 8'(i));
                x = x ^ (base + 8'(i));
            end
        end
        frm.push_back(x);
    endtask

    task automatic wait_idle(input int budget, input string name);
        bit done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (exp_cmd.size() == 0 && exp_wr.size() == 0 && exp_err.size() == 0 && !busy) begin
                done = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check(name, 32'(done), 32'd1);
    endtask

    initial begin
        bit seen;
        repeat (4) @(posedge clk);
        #1;
        check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("rst_wr_valid",  32'(wr_valid),  32'd0);
        check("rst_err_valid", 32'(err_valid), 32'd0);
        check("rst_err_code",  32'(err_code),  32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        rst = 1'b0;

        // Junk in IDLE is dropped silently.
        send_byte(8'h00, 1'b0);
        send_byte(8'hA5, 1'b1);

        // Write frame, CHK = 01^00^12^34^02^AB^CD = 43.
        exp_cmd.push_back(cmd_t'{1'b1, 24'h001234, 8'd2});
        exp_wr.push_back(8'hAB); exp_wr.push_back(8'hCD);
        frm = '{8'h55, 8'h01, 8'h00, 8'h12, 8'h34, 8'h02, 8'hAB, 8'hCD, 8'h43};
        send_frm();
        check("cmd_latency", 32'(cmd_valid), 32'd1);
        @(posedge clk); #1;
        check("wr_latency", 32'(wr_valid), 32'd1);
        wait_idle(200, "idle_write");

        // Read frame, CHK = 02^FF^FF^FF^01 = FC.
        exp_cmd.push_back(cmd_t'{1'b0, 24'hFFFFFF, 8'd1});
        frm = '{8'h55, 8'h02, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'hFC};
        send_frm();
        wait_idle(200, "idle_read");
        check("read_busy", 32'(busy), 32'd0);

        // Wrong checksum, then the good frame again.
        exp_err.push_back(3'd4);
        frm = '{8'h55, 8'h01, 8'h00, 8'h12, 8'h34, 8'h02, 8'hAB, 8'hCD, 8'h42};
        send_frm();
        wait_idle(200, "idle_badchk");
        exp_cmd.push_back(cmd_t'{1'b1, 24'h001234, 8'd2});
        exp_wr.push_back(8'hAB); exp_wr.push_back(8'hCD);
        frm = '{8'h55, 8'h01, 8'h00, 8'h12, 8'h34, 8'h02, 8'hAB, 8'hCD, 8'h43};
        send_frm();
        wait_idle(200, "idle_recover");

        // Bad command byte, bad-parity header in IDLE.
        exp_err.push_back(3'd2);
        frm = '{8'h55, 8'h07};
        send_frm();
        exp_err.push_back(3'd1);
        send_byte(8'h55, 1'b1);
        wait_idle(200, "idle_badcmd");

        // Length bounds.
        exp_err.push_back(3'd3);
        frm = '{8'h55, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
        send_frm();
        exp_err.push_back(3'd3);
        frm = '{8'h55, 8'h02, 8'h00, 8'h00, 8'h00, 8'd17};
        send_frm();
        wait_idle(200, "idle_badlen");
        exp_cmd.push_back(cmd_t'{1'b1, 24'hABCDEF, 8'd16});
        for (int i = 0; i < 16; i++) exp_wr.push_back(8'h10 + 8'(i));
        make_frame(8'h01, 24'hABCDEF, 8'd16, 8'h10);
        send_frm();
        wait_idle(400, "idle_maxlen");

        // Timeout after the second address byte.
        exp_err.push_back(3'd5);
        frm = '{8'h55, 8'h01, 8'h00, 8'h12};
        send_frm();
        wait_idle(6000, "idle_timeout");
        check("timeout_busy", 32'(busy), 32'd0);

        // Parity error on the LEN byte; code stays sticky afterwards.
        exp_err.push_back(3'd1);
        frm = '{8'h55, 8'h02, 8'h00, 8'h00, 8'h01};
        send_frm();
        send_byte(8'h01, 1'b1);
        wait_idle(200, "idle_parity");
        check("err_code_hold", 32'(err_code), 32'd1);

        // Backpressure, overrun in DRAIN, toggled wr_ready.
        cmd_ready = 1'b0; wr_ready = 1'b0;
        exp_cmd.push_back(cmd_t'{1'b1, 24'h00BEEF, 8'd4});
        for (int i = 0; i < 4; i++) exp_wr.push_back(8'h01 + 8'(i));
        make_frame(8'h01, 24'h00BEEF, 8'd4, 8'h01);
        send_frm();
        repeat (100) @(posedge clk);
        #1;
        cmd_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (wr_valid) begin seen = 1'b1; break; end
        end
        check("drain_entered", 32'(seen), 32'd1);
        cmd_ready = 1'b0;
        exp_err.push_back(3'd6);
        send_byte(8'h5A, 1'b0);
        for (int i = 0; i < 12; i++) begin
            wr_ready = (i % 3 != 0);
            @(posedge clk); #1;
        end
        wr_ready = 1'b1; cmd_ready = 1'b1;
        wait_idle(200, "idle_drain");

        check("queues_empty", 32'(exp_cmd.size() + exp_wr.size() + exp_err.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
